// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, symmetric debounce FSM and hold timer,
// producing a registered level plus single-cycle press, release and long-press strobes.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_press_pulse_o
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DebStep   = DW'(1);
    localparam logic [DW-1:0] DebLast   = DW'(DEBOUNCE_CYCLES - 1);
    localparam bit            DebSingle = (DEBOUNCE_CYCLES == 1);
    localparam logic [HW-1:0] HoldStep  = HW'(1);
    localparam logic [HW-1:0] HoldLast  = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HoldMax   = HW'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {StReleased, StPressPend, StPressed, StRelPend} state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    // The cycle that leaves a stable state already counts as the first debounce cycle,
    // so the pending count starts at 1 and the accepting edge is the one seeing dcnt = D-1.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            StReleased: begin
                if (s2_q) begin
                    if (DebSingle) begin
                        state_d = StPressed;
                        press_d = 1'b1;
                    end else begin
                        state_d = StPressPend;
                        dcnt_d  = DebStep;
                    end
                end
            end
            StPressPend: begin
                if (!s2_q) begin
                    state_d = StReleased;
                    dcnt_d  = '0;
                end else if (dcnt_q == DebLast) begin
                    state_d = StPressed;
                    dcnt_d  = '0;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DebStep;
                end
            end
            StPressed: begin
                if (!s2_q) begin
                    if (DebSingle) begin
                        state_d   = StReleased;
                        release_d = 1'b1;
                    end else begin
                        state_d = StRelPend;
                        dcnt_d  = DebStep;
                    end
                end
            end
            StRelPend: begin
                if (s2_q) begin
                    state_d = StPressed;
                    dcnt_d  = '0;
                end else if (dcnt_q == DebLast) begin
                    state_d   = StReleased;
                    dcnt_d    = '0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DebStep;
                end
            end
            default: begin
                state_d = StReleased;
                dcnt_d  = '0;
            end
        endcase
    end

    // Long-press fires on the step into HoldMax even if that edge is also the release edge.
    always_comb begin
        level_d = (state_d == StPressed) || (state_d == StRelPend);
        long_d  = level_q && (hcnt_q == HoldLast);
        hcnt_d  = hcnt_q;
        if ((state_d == StReleased) || press_d) begin
            hcnt_d = '0;
        end else if (level_q && (hcnt_q != HoldMax)) begin
            hcnt_d = hcnt_q + HoldStep;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StReleased;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= btn_raw_i ^ ACTIVE_LOW;
            s2_q      <= s1_q;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn_level_o        = level_q;
    assign press_pulse_o      = press_q;
    assign release_pulse_o    = release_q;
    assign long_press_pulse_o = long_q;

endmodule
